// File: rtl/red_pitaya_mix_block.sv
// red_pitaya_mix_block
//   N-channel signed linear combiner:
//     dat_o = clamp( (sum_k ACTIVE_GAIN[k] * adc_k) >>> SHIFT + OFFSET )
//   with double-buffered gains (atomic COMMIT), output hold, programmable
//   clamp limits and a sticky saturation event counter.
//
// Ports
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   adc_i         : NCH packed signed 14-bit samples, channel k at [14k+13:14k]
//   dat_o         : registered signed 14-bit result (4-register pipeline)
//   addr/wen/ren/wdata : PS register bus request
//   ack/rdata     : registered bus response, one cycle after the strobe
//
// Register map (byte addresses)
//   0x100 CTRL (bit0 COMMIT pulse, bit1 HOLD, bit2 CLRSAT pulse)
//   0x104 OFFSET, 0x108+4k SHADOW_GAIN[k], 0x180+4k ACTIVE_GAIN[k] (RO)
//   0x1F0 SATCNT (RO), 0x1F4 MAX, 0x1F8 MIN
//   0x200 SHIFT, 0x204 NCH, 0x20C GAINBITS (RO constants)
module red_pitaya_mix_block #(
  parameter int NCH                  = 4,
  parameter int GAINBITS             = 24,
  parameter int SHIFT                = 12,
  parameter int ARBITRARY_SATURATION = 1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [14*NCH-1:0]   adc_i,
  output logic [13:0]         dat_o,
  input  logic [15:0]         addr,
  input  logic                wen,
  input  logic                ren,
  output logic                ack,
  output logic [31:0]         rdata,
  input  logic [31:0]         wdata
);

  localparam int PW = 14 + GAINBITS;          // product width
  localparam int SW = PW + $clog2(NCH);       // sum width, cannot overflow
  localparam int VW = SW + 1;                 // shifted sum + offset, no wrap

  localparam logic signed [13:0] FIX_MAX = 14'sh1FFF;  //  8191
  localparam logic signed [13:0] FIX_MIN = 14'sh2000;  // -8192

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic signed [GAINBITS-1:0] shadow_q [NCH];
  logic signed [GAINBITS-1:0] active_q [NCH];
  logic signed [13:0]         offset_q;
  logic signed [13:0]         max_q;
  logic signed [13:0]         min_q;
  logic                       hold_q;
  logic [31:0]                satcnt_q;
  logic                       ack_q;
  logic [31:0]                rdata_q;
  logic [31:0]                rdata_d;

  logic wr_ctrl, wr_off, wr_max, wr_min, commit, clrsat;

  function automatic logic [15:0] sg_addr(input int unsigned k);
    return 16'(32'h108 + 4 * k);
  endfunction

  function automatic logic [15:0] ag_addr(input int unsigned k);
    return 16'(32'h180 + 4 * k);
  endfunction

  always_comb begin
    wr_ctrl = wen && (addr == 16'h0100);
    wr_off  = wen && (addr == 16'h0104);
    wr_max  = wen && (addr == 16'h01F4);
    wr_min  = wen && (addr == 16'h01F8);
    commit  = wr_ctrl && wdata[0];
    clrsat  = wr_ctrl && wdata[2];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      offset_q <= '0;
      max_q    <= FIX_MAX;
      min_q    <= FIX_MIN;
      hold_q   <= 1'b0;
    end else begin
      if (wr_ctrl) hold_q   <= wdata[1];
      if (wr_off)  offset_q <= wdata[13:0];
      if (wr_max)  max_q    <= wdata[13:0];
      if (wr_min)  min_q    <= wdata[13:0];
      for (int unsigned k = 0; k < NCH; k++) begin
        if (wen && (addr == sg_addr(k))) shadow_q[k] <= wdata[GAINBITS-1:0];
        // Commit samples the shadow value held before this edge.
        if (commit) active_q[k] <= shadow_q[k];
      end
    end
  end

  // Read mux: reflects register contents before any same-cycle write.
  always_comb begin
    rdata_d = '0;
    case (addr)
      16'h0100: rdata_d = 32'({hold_q, 1'b0});
      16'h0104: rdata_d = 32'(offset_q);
      16'h01F0: rdata_d = satcnt_q;
      16'h01F4: rdata_d = 32'(max_q);
      16'h01F8: rdata_d = 32'(min_q);
      16'h0200: rdata_d = 32'(SHIFT);
      16'h0204: rdata_d = 32'(NCH);
      16'h020C: rdata_d = 32'(GAINBITS);
      default:  rdata_d = '0;
    endcase
    for (int unsigned k = 0; k < NCH; k++) begin
      if (addr == sg_addr(k)) rdata_d = 32'(shadow_q[k]);
      if (addr == ag_addr(k)) rdata_d = 32'(active_q[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= wen | ren;
      rdata_q <= ren ? rdata_d : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: S1 sample, S2 products, S3 sum, S4 shift/offset/clamp
  // ---------------------------------------------------------------------------
  logic signed [13:0]   s1_q [NCH];
  logic signed [PW-1:0] s2_q [NCH];
  logic signed [SW-1:0] s3_q;
  logic signed [SW-1:0] s3_d;
  logic signed [SW-1:0] shifted;
  logic signed [VW-1:0] val;
  logic signed [13:0]   lim_hi;
  logic signed [13:0]   lim_lo;
  logic signed [13:0]   res;
  logic                 sat;
  logic [13:0]          dat_q;

  always_comb begin
    s3_d = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      s3_d = s3_d + SW'(s2_q[k]);
    end
  end

  always_comb begin
    shifted = s3_q >>> SHIFT;
    val     = VW'(shifted) + VW'(offset_q);
    lim_hi  = (ARBITRARY_SATURATION != 0) ? max_q : FIX_MAX;
    lim_lo  = (ARBITRARY_SATURATION != 0) ? min_q : FIX_MIN;
    sat     = 1'b0;
    res     = val[13:0];
    // MAX is tested first so an inverted MIN>MAX window still resolves
    // deterministically.
    if (val > VW'(lim_hi)) begin
      res = lim_hi;
      sat = 1'b1;
    end else if (val < VW'(lim_lo)) begin
      res = lim_lo;
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
      end
      s3_q     <= '0;
      dat_q    <= '0;
      satcnt_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        s1_q[k] <= adc_i[14*k +: 14];
        s2_q[k] <= PW'(s1_q[k]) * PW'(active_q[k]);
      end
      s3_q <= s3_d;
      if (!hold_q) dat_q <= res;
      if (clrsat) begin
        satcnt_q <= '0;
      end else if (sat && !hold_q && (satcnt_q != '1)) begin
        satcnt_q <= satcnt_q + 32'd1;
      end
    end
  end

  logic unused_wdata;
  assign unused_wdata = &{1'b0, wdata};

  assign dat_o = dat_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_red_pitaya_mix_block.sv
module tb_red_pitaya_mix_block;

  localparam int NCH = 4;
  localparam int GB  = 24;
  localparam int SH  = 12;

  logic              clk_i = 1'b0;
  logic              rstn_i = 1'b0;
  logic [14*NCH-1:0] adc_i = '0;
  logic [13:0]       dat_o;
  logic [15:0]       addr = '0;
  logic              wen = 1'b0;
  logic              ren = 1'b0;
  logic              ack;
  logic [31:0]       rdata;
  logic [31:0]       wdata = '0;

  int errors = 0;
  int checks = 0;

  // Reference model state (tracked from the bus writes the bench issues)
  int m_shadow [NCH];
  int m_active [NCH];
  int m_off, m_max, m_min;

  red_pitaya_mix_block #(
    .NCH(NCH), .GAINBITS(GB), .SHIFT(SH), .ARBITRARY_SATURATION(1)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .adc_i(adc_i), .dat_o(dat_o),
    .addr(addr), .wen(wen), .ren(ren), .ack(ack), .rdata(rdata), .wdata(wdata)
  );

  always #5 clk_i = ~clk_i;

  function automatic int sx(input logic [31:0] d, input int bits);
    logic [31:0] m;
    m = d << (32 - bits);
    return int'($signed(m)) >>> (32 - bits);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_off = 0;
    m_max = 8191;
    m_min = -8192;
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [31:0] d);
    if (a == 16'h0100 && d[0]) m_active = m_shadow;
    if (a == 16'h0104) m_off = sx(d, 14);
    if (a == 16'h01F4) m_max = sx(d, 14);
    if (a == 16'h01F8) m_min = sx(d, 14);
    for (int k = 0; k < NCH; k++)
      if (a == 16'(264 + 4 * k)) m_shadow[k] = sx(d, GB);
  endfunction

  // Plain arithmetic: weighted sum, floor division by 2^SH, offset, clamp.
  function automatic int model_out(input logic [14*NCH-1:0] v, output bit sat);
    longint s;
    logic signed [13:0] t;
    s = 0;
    for (int k = 0; k < NCH; k++) begin
      t = v[14*k +: 14];
      s = s + longint'(t) * longint'(m_active[k]);
    end
    s = s >>> SH;
    s = s + m_off;
    sat = 1'b1;
    if (s > m_max) return m_max;
    if (s < m_min) return m_min;
    sat = 1'b0;
    return int'(s);
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk_i);
    addr = a; wdata = d; wen = 1'b1;
    @(negedge clk_i);
    wen = 1'b0;
    model_write(a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic ak);
    @(negedge clk_i);
    addr = a; ren = 1'b1;
    @(negedge clk_i);
    ren = 1'b0;
    d = rdata;
    ak = ack;
  endtask

  task automatic set_adc(input int a0, input int a1, input int a2, input int a3);
    adc_i = {14'(a3), 14'(a2), 14'(a1), 14'(a0)};
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic chkdat(input string name, input int exp);
    checks++;
    if (dat_o !== 14'(exp)) begin
      errors++;
      $display("FAIL %s: dat_o got %0d expected %0d", name, $signed(dat_o), exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic ak;
    chkdat("reset_dat", 0);
    chk32("reset_ack", 32'(ack), 32'd0);
    chk32("reset_rdata", rdata, 32'd0);
    bus_read(16'h01F4, d, ak); chk32("reset_max", d, 32'h0000_1FFF); chk32("reset_ack_rd", 32'(ak), 32'd1);
    bus_read(16'h01F8, d, ak); chk32("reset_min", d, 32'hFFFF_E000);
    bus_read(16'h01F0, d, ak); chk32("reset_satcnt", d, 32'd0);
    bus_read(16'h0104, d, ak); chk32("reset_offset", d, 32'd0);
  endtask

  task automatic test_gain_commit();
    set_adc(1000, -500, 0, 0);
    bus_write(16'h0108, 32'd4096);
    bus_write(16'h010C, 32'd4096);
    repeat (5) @(negedge clk_i);
    chkdat("commit_none", 0);
    bus_write(16'h0100, 32'd1);        // ACTIVE_GAIN updates on this edge
    chkdat("commit_e0", 0);
    @(negedge clk_i); chkdat("commit_e1", 0);
    @(negedge clk_i); chkdat("commit_e2", 0);
    @(negedge clk_i); chkdat("commit_e3", 500);
  endtask

  task automatic test_offset_floor();
    bit s;
    bus_write(16'h0108, 32'd1);
    bus_write(16'h010C, 32'd0);
    bus_write(16'h0100, 32'd1);
    bus_write(16'h0104, 32'd10);
    set_adc(-1, 0, 0, 0);
    repeat (5) @(negedge clk_i);
    chkdat("floor_offset", 9);
    chkdat("floor_model", model_out(adc_i, s));
  endtask

  task automatic test_random_static();
    bit s;
    int g, lo, hi;
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NCH; k++) begin
        g = ($urandom_range(0, 1) == 1) ? (int'($urandom) >>> 8)
                                         : int'($urandom_range(0, 16383)) - 8192;
        bus_write(16'(264 + 4 * k), 32'(g));
      end
      bus_write(16'h0104, 32'(int'($urandom_range(0, 16383)) - 8192));
      hi = int'($urandom_range(0, 8191));
      lo = -int'($urandom_range(0, 8192));
      if (it % 4 == 3) begin   // inverted window
        hi = -100; lo = 100;
      end
      bus_write(16'h01F4, 32'(hi));
      bus_write(16'h01F8, 32'(lo));
      bus_write(16'h0100, 32'd1);
      set_adc(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
              int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      repeat (5) @(negedge clk_i);
      chkdat("random_static", model_out(adc_i, s));
    end
  endtask

  task automatic test_stream();
    logic [14*NCH-1:0] hist [$];
    bit s;
    for (int k = 0; k < NCH; k++)
      bus_write(16'(264 + 4 * k), 32'(int'($urandom_range(0, 16383)) - 8192));
    bus_write(16'h0104, 32'(int'($urandom_range(0, 2000)) - 1000));
    bus_write(16'h01F4, 32'd8191);
    bus_write(16'h01F8, 32'hFFFF_E000);
    bus_write(16'h0100, 32'd1);
    repeat (5) @(negedge clk_i);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (hist.size() == 4) chkdat("stream", model_out(hist.pop_front(), s));
      set_adc(int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192,
              int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192);
      hist.push_back(adc_i);
    end
  endtask

  task automatic test_clamp_counter();
    logic [31:0] v1, v2;
    bus_write(16'h0108, 32'h007F_FFFF);
    for (int k = 1; k < NCH; k++) bus_write(16'(264 + 4 * k), 32'd0);
    bus_write(16'h0104, 32'd0);
    bus_write(16'h01F4, 32'd2000);
    bus_write(16'h01F8, 32'(-2000));
    bus_write(16'h0100, 32'd1);
    set_adc(8191, 0, 0, 0);
    repeat (5) @(negedge clk_i);
    chkdat("clamp_max", 2000);
    @(negedge clk_i); addr = 16'h01F0; ren = 1'b1;
    @(negedge clk_i); v1 = rdata;
    @(negedge clk_i); v2 = rdata; ren = 1'b0;
    chk32("satcnt_step", v2, v1 + 32'd1);
    bus_write(16'h0108, 32'(-8388607));
    bus_write(16'h0100, 32'd1);
    repeat (5) @(negedge clk_i);
    chkdat("clamp_min", -2000);
    // CLRSAT on a cycle that is also saturating: clear wins, then counts on.
    @(negedge clk_i); addr = 16'h0100; wdata = 32'd4; wen = 1'b1;
    @(negedge clk_i); wen = 1'b0; addr = 16'h01F0; ren = 1'b1;
    @(negedge clk_i); v1 = rdata;
    @(negedge clk_i); v2 = rdata; ren = 1'b0;
    chk32("clrsat_zero", v1, 32'd0);
    chk32("clrsat_recount", v2, 32'd1);
  endtask

  task automatic test_hold();
    logic [31:0] v1, v2;
    bit s;
    bus_write(16'h0100, 32'd2);
    set_adc(-8191, 0, 0, 0);
    repeat (6) @(negedge clk_i);
    chkdat("hold_frozen", -2000);
    addr = 16'h01F0; ren = 1'b1;
    @(negedge clk_i); v1 = rdata;
    @(negedge clk_i); v2 = rdata; ren = 1'b0;
    chk32("hold_satcnt", v2, v1);
    bus_write(16'h0100, 32'd0);
    @(negedge clk_i);
    chkdat("hold_release", model_out(adc_i, s));
    chkdat("hold_release_val", 2000);
  endtask

  task automatic test_bus_map();
    logic [31:0] d;
    logic ak;
    bus_read(16'h0200, d, ak); chk32("const_shift", d, 32'd12);
    bus_read(16'h0204, d, ak); chk32("const_nch", d, 32'd4);
    bus_read(16'h020C, d, ak); chk32("const_gainbits", d, 32'd24);
    bus_read(16'h0300, d, ak); chk32("unmapped_data", d, 32'd0); chk32("unmapped_ack", 32'(ak), 32'd1);
    @(negedge clk_i); chk32("ack_drop", 32'(ack), 32'd0);
    bus_write(16'h0110, 32'hFFFF_FFFB);
    bus_read(16'h0110, d, ak); chk32("gain_neg", d, 32'hFFFF_FFFB);
    bus_write(16'h0110, 32'h0080_0000);
    bus_read(16'h0110, d, ak); chk32("gain_signext", d, 32'hFF80_0000);
    bus_write(16'h0114, 32'h1234_5678);
    bus_read(16'h0114, d, ak); chk32("gain_trunc", d, 32'h0034_5678);
    bus_write(16'h0200, 32'd99);
    bus_read(16'h0200, d, ak); chk32("ro_const", d, 32'd12);
    bus_write(16'h0180, 32'd77);
    bus_read(16'h0180, d, ak); chk32("ro_active", d, 32'(m_active[0]));
    bus_read(16'h0100, d, ak); chk32("ctrl_read", d, 32'd0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk_i); addr = 16'h0104; wdata = 32'd321; wen = 1'b1; ren = 1'b1;
    @(negedge clk_i); wen = 1'b0;
    chk32("b2b_old", rdata, 32'(m_off));
    chk32("b2b_ack1", 32'(ack), 32'd1);
    model_write(16'h0104, 32'd321);
    @(negedge clk_i); ren = 1'b0;
    chk32("b2b_new", rdata, 32'd321);
    chk32("b2b_ack2", 32'(ack), 32'd1);
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    logic ak;
    bus_write(16'h0108, 32'h007F_FFFF);
    bus_write(16'h0104, 32'd0);
    bus_write(16'h01F4, 32'd2000);
    bus_write(16'h0100, 32'd1);
    set_adc(8191, 0, 0, 0);
    repeat (5) @(negedge clk_i);
    chkdat("pre_reset", 2000);
    #2 rstn_i = 1'b0;
    #1;
    chkdat("async_dat", 0);
    #1 rstn_i = 1'b1;
    model_reset();
    bus_read(16'h01F0, d, ak); chk32("async_satcnt", d, 32'd0);
    bus_read(16'h0180, d, ak); chk32("async_active", d, 32'd0);
    bus_read(16'h01F4, d, ak); chk32("async_max", d, 32'h0000_1FFF);
    bus_read(16'h01F8, d, ak); chk32("async_min", d, 32'hFFFF_E000);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    test_reset();
    test_gain_commit();
    test_offset_floor();
    test_random_static();
    test_stream();
    test_clamp_counter();
    test_hold();
    test_bus_map();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
